// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C register-target block.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK
  } state_t;

  localparam logic ACK        = 1'b0;
  localparam logic NACK       = 1'b1;
  localparam int   BYTE_BITS  = 8;
  localparam int   RD_LATENCY = 2;

  // Bit-counter value once a full byte has been clocked in.
  localparam logic [3:0] LAST_BIT = 4'(BYTE_BITS);

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronises and deglitches SCL/SDA, then derives SCL edges and START/STOP.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start_det,
  output logic o_stop_det
);

  // Index 0 is SCL, index 1 is SDA.
  logic [1:0] w_raw;
  logic [1:0] w_filt;
  logic [1:0] w_prev;

  assign w_raw = {i_sda, i_scl};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      logic [1:0]            r_sync;
      logic [FILTER_LEN-1:0] r_hist;
      logic                  r_filt;
      logic                  r_prev;

      // Level only moves once FILTER_LEN consecutive samples agree.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_sync <= 2'b11;
          r_hist <= '1;
          r_filt <= 1'b1;
          r_prev <= 1'b1;
        end else begin
          r_sync <= {r_sync[0], w_raw[gi]};
          r_hist <= {r_hist[FILTER_LEN-2:0], r_sync[1]};
          if (&r_hist) begin
            r_filt <= 1'b1;
          end else if (~|r_hist) begin
            r_filt <= 1'b0;
          end
          r_prev <= r_filt;
        end
      end

      assign w_filt[gi] = r_filt;
      assign w_prev[gi] = r_prev;
    end
  endgenerate

  assign o_sda       = w_filt[1];
  assign o_scl_rise  =  w_filt[0] & ~w_prev[0];
  assign o_scl_fall  = ~w_filt[0] &  w_prev[0];
  assign o_start_det =  w_filt[0] &  w_prev[0] &  w_prev[1] & ~w_filt[1];
  assign o_stop_det  =  w_filt[0] &  w_prev[0] & ~w_prev[1] &  w_filt[1];

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing an 8-bit register space through write/read strobes.
module i2c_target_regs
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_req,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0] w_byte;
  logic w_last_bit, w_rd_ack;

  state_t     r_state;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_ptr;
  logic       r_rw;
  logic       r_sda_low;
  logic       r_busy;
  logic       r_wr_en;
  logic [7:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic       r_rd_req;
  logic [7:0] r_rd_addr;
  logic [1:0] r_rd_cnt;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk         (clk),
    .reset       (reset),
    .i_scl       (scl),
    .i_sda       (sda),
    .o_sda       (w_sda),
    .o_scl_rise  (w_scl_rise),
    .o_scl_fall  (w_scl_fall),
    .o_start_det (w_start),
    .o_stop_det  (w_stop)
  );

  assign w_byte     = {r_shift[6:0], w_sda};
  assign w_last_bit = w_scl_rise && (r_bit_cnt == LAST_BIT - 4'd1);
  assign w_rd_ack   = (r_state == ST_ADDR_ACK) && r_rw;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_ptr     <= '0;
      r_rw      <= 1'b0;
      r_sda_low <= 1'b0;
      r_busy    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_rd_req  <= 1'b0;
      r_rd_addr <= '0;
      r_rd_cnt  <= '0;
    end else begin
      r_wr_en  <= 1'b0;
      r_rd_req <= 1'b0;
      if (r_rd_cnt != 2'd0) r_rd_cnt <= r_rd_cnt - 2'd1;

      if (w_start || w_stop) begin
        r_state   <= w_start ? ST_ADDR : ST_IDLE;
        r_bit_cnt <= '0;
        r_sda_low <= 1'b0;
        r_busy    <= 1'b0;
        r_rd_cnt  <= '0;
      end else begin
        // Parent's read data lands RD_LATENCY clocks after rd_req.
        if (r_rd_cnt == 2'd1) begin
          r_shift <= rd_data;
          if (r_state == ST_RDATA) r_sda_low <= ~rd_data[7];
        end

        case (r_state)
          ST_ADDR: if (w_scl_rise) begin
            r_shift   <= w_byte;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (w_last_bit) begin
              if (w_byte[7:1] == TARGET_ADDR) begin
                r_state <= ST_ADDR_ACK;
                r_busy  <= 1'b1;
                r_rw    <= w_byte[0];
              end else begin
                r_state <= ST_IDLE;
              end
            end
          end

          ST_REG: if (w_scl_rise) begin
            r_shift   <= w_byte;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (w_last_bit) begin
              r_ptr   <= w_byte;
              r_state <= ST_REG_ACK;
            end
          end

          ST_WDATA: if (w_scl_rise) begin
            r_shift   <= w_byte;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (w_last_bit) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_ptr;
              r_wr_data <= w_byte;
              r_ptr     <= r_ptr + 8'd1;
              r_state   <= ST_WDATA_ACK;
            end
          end

          // Counter reads 8 on the fall that ends the byte, 9 after the ACK clock.
          ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && r_bit_cnt == LAST_BIT) begin
              r_sda_low <= 1'b1;
              if (w_rd_ack) begin
                r_rd_req  <= 1'b1;
                r_rd_addr <= r_ptr;
                r_rd_cnt  <= 2'(RD_LATENCY);
              end
            end else if (w_scl_fall && r_bit_cnt == LAST_BIT + 4'd1) begin
              r_bit_cnt <= '0;
              if (w_rd_ack) begin
                r_state   <= ST_RDATA;
                r_sda_low <= ~r_shift[7];
              end else begin
                r_state   <= (r_state == ST_ADDR_ACK) ? ST_REG : ST_WDATA;
                r_sda_low <= 1'b0;
              end
            end
          end

          ST_RDATA: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && r_bit_cnt == LAST_BIT) begin
              r_state   <= ST_RDATA_ACK;
              r_sda_low <= 1'b0;
            end else if (w_scl_fall && r_bit_cnt != 4'd0) begin
              r_shift   <= {r_shift[6:0], 1'b0};
              r_sda_low <= ~r_shift[6];
            end
          end

          // Controller's ACK bit is parked in r_shift[0]; after a NACK nothing moves.
          ST_RDATA_ACK: begin
            if (w_scl_rise && r_bit_cnt == LAST_BIT) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
              r_shift   <= w_byte;
            end else if (w_scl_fall && r_bit_cnt == LAST_BIT + 4'd1 && r_shift[0] == ACK) begin
              r_ptr     <= r_ptr + 8'd1;
              r_rd_req  <= 1'b1;
              r_rd_addr <= r_ptr + 8'd1;
              r_rd_cnt  <= 2'(RD_LATENCY);
              r_state   <= ST_RDATA;
              r_bit_cnt <= '0;
              r_sda_low <= 1'b0;
            end
          end

          default: ;
        endcase
      end
    end
  end

  assign sda     = r_sda_low ? 1'b0 : 1'bz;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign rd_req  = r_rd_req;
  assign rd_addr = r_rd_addr;
  assign busy    = r_busy;

endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
- I2C target (responder) that exposes an 8-bit-addressed register space to an external I2C controller (debug/config MCU). It is the counterpart of the FPGA-side I2C initiator path used for transmitter setup.
- The block oversamples SCL and SDA on the system clock and decodes START, repeated START and STOP.
- It matches a 7-bit device address and runs register-pointer write, burst-write and burst-read transfers.
- It presents a simple strobe interface to a register file owned by the parent module.

Parameters:
- TARGET_ADDR, 7'h42: 7-bit device address this block responds to.
- FILTER_LEN, 3: consecutive equal samples required before a filtered SCL/SDA level changes (glitch reject).

Ports:
- clk, input, 1: system clock (25.2 MHz nominal; must be ≥ 20x SCL rate).
- reset, input, 1: synchronous, active-high reset.
- scl, input, 1: I2C clock from the controller. No clock stretching.
- sda, inout, 1: I2C data. Open-drain: driven 1'b0 or 1'bz only.
- wr_en, output, 1: one-clk pulse; a register write is committed.
- wr_addr, output, 8: register address for wr_en.
- wr_data, output, 8: write data for wr_en.
- rd_req, output, 1: one-clk pulse; the parent must present rd_data for rd_addr.
- rd_addr, output, 8: register address being read.
- rd_data, input, 8: read data; sampled exactly 2 clk after rd_req.
- busy, output, 1: high from an address match until STOP or any START.

Behaviour:
- Reset values: wr_en=0, rd_req=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0, sda released (z), reg pointer=0, state=IDLE. Reset mid-transfer aborts immediately with no wr_en.
- Input conditioning: 2-FF synchroniser, then the FILTER_LEN majority/persistence filter, then edge detect.
- START = filtered SDA falls while SCL is high. STOP = filtered SDA rises while SCL is high.
- Data bits are sampled on the filtered SCL rising edge, MSB first.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- START or repeated START from any state: go to ADDR, clear the bit counter, release sda.
- STOP from any state: go to IDLE, release sda, busy=0. A partial byte is discarded and produces no wr_en.
- ADDR: after 8 bits, compare [7:1] with TARGET_ADDR.
  - Mismatch: IDLE; sda never driven (NACK).
  - Match: ADDR_ACK; busy=1.
- ADDR_ACK: drive sda=0 from the SCL falling edge after bit 8 until the SCL falling edge after the 9th clock.
  - R/W=0: go to REG.
  - R/W=1: go to RDATA. Pulse rd_req with rd_addr=pointer at the falling edge that ends bit 8. Load the shift register from rd_data 2 clk later.
- REG: 8 bits load the pointer, then REG_ACK (ACK), then WDATA.
- WDATA: 8 bits, then WDATA_ACK (ACK). Pulse wr_en for 1 clk with wr_addr=pointer and wr_data=byte; this occurs within 3 clk of the 8th SCL rise. Then pointer+1 (8-bit wrap 0xFF→0x00) and stay in WDATA.
- RDATA: drive each bit on sda (0 → drive 0, 1 → release) starting at the SCL falling edge. Release sda after bit 8, then go to RDATA_ACK.
- RDATA_ACK: sample the controller's ACK on the 9th SCL rise.
  - ACK (sda=0): pointer+1 (wrap). Pulse rd_req at the 9th SCL fall, reload the shift register, return to RDATA.
  - NACK: release sda and wait in RDATA_ACK for STOP or START. No further rd_req.
- Pointer persistence: the pointer survives STOP, so a write of only the REG byte followed by repeated START+read reads from the new pointer.
- Simultaneous events in one clk: START/STOP detection takes priority over bit sampling.
- Simultaneous events in one clk: reset takes priority over everything.

Decomposition:
- Package i2c_target_pkg: state enum; constants ACK=1'b0 and NACK=1'b1; BYTE_BITS=8; RD_LATENCY=2.
- Sub-module i2c_line_filter: synchroniser, FILTER_LEN filter, scl_rise/scl_fall, start_det/stop_det outputs.
- i2c_target_regs instantiates it once and holds the FSM, shift register, pointer and sda driver.

Test Plan:
- Write S,0x84,0x10,0xA5,P: three ACKs; one wr_en with wr_addr=0x10, wr_data=0xA5; busy returns 0 after P.
- Address mismatch S,0x86,…: sda never driven, busy stays 0, no wr_en/rd_req.
- Burst write S,0x84,0xFE,0x11,0x22,0x33,P: wr_en at addresses 0xFE, 0xFF, 0x00 with data 0x11, 0x22, 0x33 (pointer wrap).
- Pointer set then read S,0x84,0x20,Sr,0x85,read×2 (ACK then NACK),P; model returns 0x5A/0xC3: bytes 0x5A, 0xC3 on sda; rd_addr 0x20 then 0x21; no third rd_req.
- Abort: STOP after 4 data bits of a WDATA byte gives no wr_en, state IDLE. Assert reset mid-RDATA with bit value 0: sda released on the next clk and all outputs at reset values.
- Glitch: a 1-clk low pulse on SCL while SDA toggles causes no bit sampled and no false START/STOP (FILTER_LEN=3).
